// File: rtl/src_ctrl_pkg.sv
// Mini-SRC control unit shared types:
// opcodes, FSM states, instruction classes, strobe bundle.
package src_ctrl_pkg;

   localparam logic [4:0] OP_LD   = 5'b00000;
   localparam logic [4:0] OP_LDI  = 5'b00001;
   localparam logic [4:0] OP_ST   = 5'b00010;
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_ROR  = 5'b00111;
   localparam logic [4:0] OP_ROL  = 5'b01000;
   localparam logic [4:0] OP_SHR  = 5'b01001;
   localparam logic [4:0] OP_SHRA = 5'b01010;
   localparam logic [4:0] OP_SHL  = 5'b01011;
   localparam logic [4:0] OP_ADDI = 5'b01100;
   localparam logic [4:0] OP_ANDI = 5'b01101;
   localparam logic [4:0] OP_ORI  = 5'b01110;
   localparam logic [4:0] OP_MUL  = 5'b01111;
   localparam logic [4:0] OP_DIV  = 5'b10000;
   localparam logic [4:0] OP_NEG  = 5'b10001;
   localparam logic [4:0] OP_NOT  = 5'b10010;
   localparam logic [4:0] OP_MFHI = 5'b11000;
   localparam logic [4:0] OP_MFLO = 5'b11001;
   localparam logic [4:0] OP_NOP  = 5'b11010;
   localparam logic [4:0] OP_HALT = 5'b11011;

   localparam logic [4:0] ALU_ADD  = 5'b00011;
   localparam logic [4:0] ALU_NONE = 5'b00000;

   typedef enum logic [3:0] {
      S_RST, S_T0, S_T1, S_T2, S_T3,
      S_T4, S_T5, S_T6, S_T7, S_HALTED
   } state_t;

   typedef enum logic [3:0] {
      C_LD, C_LDI, C_ST, C_RFMT, C_IMM,
      C_UNARY, C_MULDIV, C_MFHI, C_MFLO,
      C_NOP, C_HALT, C_ILL
   } iclass_t;

   typedef struct packed {
      logic       pc_out;
      logic       zhigh_out;
      logic       zlow_out;
      logic       mdr_out;
      logic       hi_out;
      logic       lo_out;
      logic       ba_out;
      logic       c_out;
      logic       mar_in;
      logic       pc_in;
      logic       mdr_in;
      logic       ir_in;
      logic       y_in;
      logic       hi_in;
      logic       lo_in;
      logic       zhigh_in;
      logic       zlow_in;
      logic       gra;
      logic       grb;
      logic       grc;
      logic       r_in;
      logic       r_out;
      logic       inc_pc;
      logic       read;
      logic       write;
      logic [4:0] alu_op;
      logic       run;
      logic       illegal;
   } ctrl_t;

   function automatic iclass_t op_class(input logic [4:0] op);
      iclass_t c;
      case (op)
         OP_LD:   c = C_LD;
         OP_LDI:  c = C_LDI;
         OP_ST:   c = C_ST;
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
         OP_ROL, OP_SHR, OP_SHRA, OP_SHL:
                  c = C_RFMT;
         OP_ADDI, OP_ANDI, OP_ORI:
                  c = C_IMM;
         OP_MUL, OP_DIV:
                  c = C_MULDIV;
         OP_NEG, OP_NOT:
                  c = C_UNARY;
         OP_MFHI: c = C_MFHI;
         OP_MFLO: c = C_MFLO;
         OP_NOP:  c = C_NOP;
         OP_HALT: c = C_HALT;
         default: c = C_ILL;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/control_sequencer_decode.sv
// Moore output decode: FSM state plus opcode
// to the full datapath strobe bundle.
module ctrl_decode
   import src_ctrl_pkg::*;
(
   input  state_t     state,
   input  logic [4:0] opcode,
   output ctrl_t      ctrl
);

   iclass_t cls;

   assign cls = op_class(opcode);

   // strobes per state; anything not named stays 0
   always_comb begin
      ctrl     = '0;
      ctrl.run = 1'b1;
      unique case (state)
         S_RST: ;
         S_T0: begin
            ctrl.pc_out  = 1'b1;
            ctrl.mar_in  = 1'b1;
            ctrl.inc_pc  = 1'b1;
            ctrl.zlow_in = 1'b1;
         end
         S_T1: begin
            ctrl.zlow_out = 1'b1;
            ctrl.pc_in    = 1'b1;
            ctrl.read     = 1'b1;
            ctrl.mdr_in   = 1'b1;
         end
         S_T2: begin
            ctrl.mdr_out = 1'b1;
            ctrl.ir_in   = 1'b1;
         end
         S_T3: begin
            case (cls)
               C_RFMT, C_IMM: begin
                  ctrl.grb   = 1'b1;
                  ctrl.r_out = 1'b1;
                  ctrl.y_in  = 1'b1;
               end
               C_UNARY: begin
                  ctrl.grb     = 1'b1;
                  ctrl.r_out   = 1'b1;
                  ctrl.zlow_in = 1'b1;
                  ctrl.alu_op  = opcode;
               end
               C_MULDIV: begin
                  ctrl.gra   = 1'b1;
                  ctrl.r_out = 1'b1;
                  ctrl.y_in  = 1'b1;
               end
               C_MFHI: begin
                  ctrl.hi_out = 1'b1;
                  ctrl.gra    = 1'b1;
                  ctrl.r_in   = 1'b1;
               end
               C_MFLO: begin
                  ctrl.lo_out = 1'b1;
                  ctrl.gra    = 1'b1;
                  ctrl.r_in   = 1'b1;
               end
               C_LD, C_LDI, C_ST: begin
                  ctrl.grb    = 1'b1;
                  ctrl.ba_out = 1'b1;
                  ctrl.y_in   = 1'b1;
               end
               C_ILL: ctrl.illegal = 1'b1;
               default: ;
            endcase
         end
         S_T4: begin
            case (cls)
               C_RFMT: begin
                  ctrl.grc     = 1'b1;
                  ctrl.r_out   = 1'b1;
                  ctrl.zlow_in = 1'b1;
                  ctrl.alu_op  = opcode;
               end
               C_IMM: begin
                  ctrl.c_out   = 1'b1;
                  ctrl.zlow_in = 1'b1;
                  ctrl.alu_op  = opcode;
               end
               C_UNARY: begin
                  ctrl.zlow_out = 1'b1;
                  ctrl.gra      = 1'b1;
                  ctrl.r_in     = 1'b1;
               end
               C_MULDIV: begin
                  ctrl.grb      = 1'b1;
                  ctrl.r_out    = 1'b1;
                  ctrl.zhigh_in = 1'b1;
                  ctrl.zlow_in  = 1'b1;
                  ctrl.alu_op   = opcode;
               end
               C_LD, C_LDI, C_ST: begin
                  ctrl.c_out   = 1'b1;
                  ctrl.zlow_in = 1'b1;
                  ctrl.alu_op  = ALU_ADD;
               end
               default: ;
            endcase
         end
         S_T5: begin
            case (cls)
               C_RFMT, C_IMM, C_LDI: begin
                  ctrl.zlow_out = 1'b1;
                  ctrl.gra      = 1'b1;
                  ctrl.r_in     = 1'b1;
               end
               C_MULDIV: begin
                  ctrl.zlow_out = 1'b1;
                  ctrl.lo_in    = 1'b1;
               end
               C_LD, C_ST: begin
                  ctrl.zlow_out = 1'b1;
                  ctrl.mar_in   = 1'b1;
               end
               default: ;
            endcase
         end
         S_T6: begin
            case (cls)
               C_MULDIV: begin
                  ctrl.zhigh_out = 1'b1;
                  ctrl.hi_in     = 1'b1;
               end
               C_LD: begin
                  ctrl.read   = 1'b1;
                  ctrl.mdr_in = 1'b1;
               end
               C_ST: begin
                  ctrl.gra    = 1'b1;
                  ctrl.r_out  = 1'b1;
                  ctrl.mdr_in = 1'b1;
               end
               default: ;
            endcase
         end
         S_T7: begin
            case (cls)
               C_LD: begin
                  ctrl.mdr_out = 1'b1;
                  ctrl.gra     = 1'b1;
                  ctrl.r_in    = 1'b1;
               end
               C_ST: ctrl.write = 1'b1;
               default: ;
            endcase
         end
         S_HALTED: ctrl.run = 1'b0;
         default: ;
      endcase
   end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Mini-SRC control unit: state register,
// memory wait counter and T-state sequencing.
module control_sequencer
   import src_ctrl_pkg::*;
#(
   parameter int MEM_LATENCY = 1,
   parameter int CNT_W       = 4
) (
   input  logic        clock,
   input  logic        clear,
   input  logic [31:0] ir,
   output logic        PCout,
   output logic        Zhighout,
   output logic        Zlowout,
   output logic        MDRout,
   output logic        HIout,
   output logic        LOout,
   output logic        BAout,
   output logic        Cout,
   output logic        MARin,
   output logic        PCin,
   output logic        MDRin,
   output logic        IRin,
   output logic        Yin,
   output logic        HIin,
   output logic        LOin,
   output logic        Zhighin,
   output logic        Zlowin,
   output logic        Gra,
   output logic        Grb,
   output logic        Grc,
   output logic        Rin,
   output logic        Rout,
   output logic        IncPC,
   output logic        Read,
   output logic        Write,
   output logic [4:0]  alu_op,
   output logic        run,
   output logic        illegal
);

   localparam logic [CNT_W-1:0] CNT_LAST =
      CNT_W'(MEM_LATENCY - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [4:0]       opcode;
   iclass_t          cls;
   logic             mem_done;
   ctrl_t            ctrl;
   logic             unused_ir;

   assign opcode    = ir[31:27];
   assign unused_ir = ^ir[26:0];
   assign cls       = op_class(opcode);
   assign mem_done  = (cnt_q == CNT_LAST);

   // next state; counter counts only while a memory
   // state is held and is 0 on entry to any state
   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      unique case (state_q)
         S_RST: state_d = S_T0;
         S_T0:  state_d = S_T1;
         S_T1: begin
            if (mem_done) state_d = S_T2;
            else cnt_d = cnt_q + CNT_W'(1);
         end
         S_T2:  state_d = S_T3;
         S_T3: begin
            case (cls)
               C_NOP, C_MFHI, C_MFLO, C_ILL:
                  state_d = S_T0;
               C_HALT:  state_d = S_HALTED;
               default: state_d = S_T4;
            endcase
         end
         S_T4: begin
            if (cls == C_UNARY) state_d = S_T0;
            else state_d = S_T5;
         end
         S_T5: begin
            case (cls)
               C_LD, C_ST, C_MULDIV: state_d = S_T6;
               default:              state_d = S_T0;
            endcase
         end
         S_T6: begin
            case (cls)
               C_LD: begin
                  if (mem_done) state_d = S_T7;
                  else cnt_d = cnt_q + CNT_W'(1);
               end
               C_ST:    state_d = S_T7;
               default: state_d = S_T0;
            endcase
         end
         S_T7: begin
            if (cls == C_ST && !mem_done)
               cnt_d = cnt_q + CNT_W'(1);
            else
               state_d = S_T0;
         end
         S_HALTED: state_d = S_HALTED;
         default:  state_d = S_RST;
      endcase
   end

   // state and wait counter; clear wins from any state
   always_ff @(posedge clock) begin
      if (clear) begin
         state_q <= S_RST;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   ctrl_decode u_decode (
      .state  (state_q),
      .opcode (opcode),
      .ctrl   (ctrl)
   );

   assign PCout    = ctrl.pc_out;
   assign Zhighout = ctrl.zhigh_out;
   assign Zlowout  = ctrl.zlow_out;
   assign MDRout   = ctrl.mdr_out;
   assign HIout    = ctrl.hi_out;
   assign LOout    = ctrl.lo_out;
   assign BAout    = ctrl.ba_out;
   assign Cout     = ctrl.c_out;
   assign MARin    = ctrl.mar_in;
   assign PCin     = ctrl.pc_in;
   assign MDRin    = ctrl.mdr_in;
   assign IRin     = ctrl.ir_in;
   assign Yin      = ctrl.y_in;
   assign HIin     = ctrl.hi_in;
   assign LOin     = ctrl.lo_in;
   assign Zhighin  = ctrl.zhigh_in;
   assign Zlowin   = ctrl.zlow_in;
   assign Gra      = ctrl.gra;
   assign Grb      = ctrl.grb;
   assign Grc      = ctrl.grc;
   assign Rin      = ctrl.r_in;
   assign Rout     = ctrl.r_out;
   assign IncPC    = ctrl.inc_pc;
   assign Read     = ctrl.read;
   assign Write    = ctrl.write;
   assign alu_op   = ctrl.alu_op;
   assign run      = ctrl.run;
   assign illegal  = ctrl.illegal;

endmodule
